// File: rtl/nbr_list_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nbr_list_reader: looks up one vertex record in the neighbor RAM and streams |
// | its neighbor indices on a valid/ready port. Option macro: NBR_PREFETCH_EN. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nbr_list_reader #(
  parameter int MAX_NEIGHBOR_COUNT = 10,
  parameter int VERTEX_MAX         = 51
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_vertex,
  output logic        nbr_valid,
  input  logic        nbr_ready,
  output logic [31:0] nbr_vertex,
  output logic        nbr_last,
  output logic        done,
  output logic [3:0]  done_count,
  output logic        done_err,
  output logic        busy,
  output logic        RAM_NBR_EN,
  output logic [8:0]  RAM_NBR_A,
  output logic [3:0]  RAM_NBR_WE,
  output logic [31:0] RAM_NBR_Di,
  input  logic [31:0] RAM_NBR_Do
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CNT_WAIT = 3'd1,
    S_CNT_CAP  = 3'd2,
    S_NBR_WAIT = 3'd3,
    S_NBR_CAP  = 3'd4,
    S_EMIT     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [3:0] c_CNT_MAX  = 4'(MAX_NEIGHBOR_COUNT - 1);
  localparam logic [8:0] c_REC_SIZE = 9'(MAX_NEIGHBOR_COUNT);

  state_t      r_state;
  state_t      w_state_next;
  logic [8:0]  r_base;
  logic [3:0]  r_cnt;
  logic [3:0]  r_beats;
  logic        r_err;

  logic        w_accept;
  logic        w_legal;
  logic [8:0]  w_base;
  logic        w_cnt_ovf;
  logic [3:0]  w_cnt_cap;
  logic        w_fire;

  assign RAM_NBR_WE = 4'd0;
  assign RAM_NBR_Di = 32'd0;

  always_comb begin
    w_accept  = req_valid && req_ready;
    w_legal   = (req_vertex != 32'd0) && (req_vertex <= 32'(VERTEX_MAX));
    w_base    = (req_vertex[8:0] - 9'd1) * c_REC_SIZE;
    w_cnt_ovf = (RAM_NBR_Do[3:0] > c_CNT_MAX);
    w_cnt_cap = w_cnt_ovf ? c_CNT_MAX : RAM_NBR_Do[3:0];
    w_fire    = nbr_valid && nbr_ready;
  end

`ifdef NBR_PREFETCH_EN
  // Read pipeline: r_a_* tags the address on the bus, r_do_* the word on Do.
  // Held addresses re-read the same word, so a rejected word is simply refetched.
  logic [31:0] r_hold;
  logic        r_hold_v;
  logic        r_hold_last;
  logic [3:0]  r_next_k;
  logic [3:0]  r_a_k;
  logic        r_a_v;
  logic [3:0]  r_do_k;
  logic        r_dv;
  logic        w_take;
  logic        w_acc;
  logic        w_do_last;
  logic [3:0]  w_next_k;
  logic [3:0]  w_tgt;
  logic        w_issue;

  always_comb begin
    w_take    = r_dv && (r_do_k == r_next_k) && (r_next_k < r_cnt);
    w_acc     = w_take && (w_fire || !nbr_valid || !r_hold_v);
    w_do_last = (r_next_k == (r_cnt - 4'd1));
    w_next_k  = r_next_k + {3'd0, w_acc};
    w_tgt     = w_next_k + {3'd0, (r_a_v && (r_a_k == w_next_k))};
    w_issue   = (w_tgt < r_cnt);
  end
`else
  logic [3:0]  r_k;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_state_next = w_legal ? S_CNT_WAIT : S_DONE;
      S_CNT_WAIT: w_state_next = S_CNT_CAP;
      S_CNT_CAP:  w_state_next = (w_cnt_cap == 4'd0) ? S_DONE : S_NBR_WAIT;
      S_NBR_WAIT: w_state_next = S_NBR_CAP;
      S_NBR_CAP:  w_state_next = S_EMIT;
      S_EMIT: begin
        if (w_fire && nbr_last) w_state_next = S_DONE;
`ifndef NBR_PREFETCH_EN
        else if (w_fire)        w_state_next = S_NBR_WAIT;
`endif
      end
      S_DONE:     w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready   <= 1'b1;
      nbr_valid   <= 1'b0;
      nbr_vertex  <= 32'd0;
      nbr_last    <= 1'b0;
      done        <= 1'b0;
      done_count  <= 4'd0;
      done_err    <= 1'b0;
      busy        <= 1'b0;
      RAM_NBR_EN  <= 1'b0;
      RAM_NBR_A   <= 9'd0;
      r_base      <= 9'd0;
      r_cnt       <= 4'd0;
      r_beats     <= 4'd0;
      r_err       <= 1'b0;
`ifdef NBR_PREFETCH_EN
      r_hold      <= 32'd0;
      r_hold_v    <= 1'b0;
      r_hold_last <= 1'b0;
      r_next_k    <= 4'd0;
      r_a_k       <= 4'd0;
      r_a_v       <= 1'b0;
      r_do_k      <= 4'd0;
      r_dv        <= 1'b0;
`else
      r_k         <= 4'd0;
`endif
    end else begin
      RAM_NBR_EN <= 1'b1;
      done       <= 1'b0;
      req_ready  <= (w_state_next == S_IDLE);
      // Stays high through the done cycle so busy drops on the edge after done.
      busy       <= (w_state_next != S_IDLE) || (r_state == S_DONE);
`ifdef NBR_PREFETCH_EN
      r_dv       <= 1'b0;
      r_a_v      <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_base  <= w_base;
            r_err   <= !w_legal;
            r_cnt   <= 4'd0;
            r_beats <= 4'd0;
            if (w_legal) RAM_NBR_A <= w_base;
          end
        end
        S_CNT_CAP: begin
          r_cnt <= w_cnt_cap;
          if (w_cnt_ovf) r_err <= 1'b1;
          if (w_cnt_cap != 4'd0) begin
            RAM_NBR_A <= r_base + 9'd1;
`ifdef NBR_PREFETCH_EN
            r_next_k  <= 4'd0;
            r_a_k     <= 4'd0;
            r_a_v     <= 1'b1;
            r_hold_v  <= 1'b0;
`else
            r_k       <= 4'd0;
`endif
          end
        end
`ifndef NBR_PREFETCH_EN
        S_NBR_CAP: begin
          nbr_vertex <= RAM_NBR_Do;
          nbr_last   <= (r_k == (r_cnt - 4'd1));
          nbr_valid  <= 1'b1;
        end
        S_EMIT: begin
          if (w_fire) begin
            r_beats   <= r_beats + 4'd1;
            nbr_valid <= 1'b0;
            nbr_last  <= 1'b0;
            if (!nbr_last) begin
              r_k       <= r_k + 4'd1;
              RAM_NBR_A <= RAM_NBR_A + 9'd1;
            end
          end
        end
`endif
        S_DONE: begin
          done       <= 1'b1;
          done_count <= r_beats;
          done_err   <= r_err;
          RAM_NBR_A  <= 9'd0;
        end
        default: ;
      endcase

`ifdef NBR_PREFETCH_EN
      if ((r_state == S_NBR_WAIT) || (r_state == S_NBR_CAP) || (r_state == S_EMIT)) begin
        r_dv     <= r_a_v;
        r_do_k   <= r_a_k;
        r_next_k <= w_next_k;
        if (w_issue) begin
          RAM_NBR_A <= r_base + 9'd1 + {5'd0, w_tgt};
          r_a_k     <= w_tgt;
          r_a_v     <= 1'b1;
        end
        if (w_fire) begin
          r_beats <= r_beats + 4'd1;
          if (r_hold_v) begin
            nbr_vertex <= r_hold;
            nbr_last   <= r_hold_last;
            r_hold_v   <= w_acc;
            if (w_acc) begin
              r_hold      <= RAM_NBR_Do;
              r_hold_last <= w_do_last;
            end
          end else if (w_acc) begin
            nbr_vertex <= RAM_NBR_Do;
            nbr_last   <= w_do_last;
          end else begin
            nbr_valid <= 1'b0;
            nbr_last  <= 1'b0;
          end
        end else if (w_acc && !nbr_valid) begin
          nbr_vertex <= RAM_NBR_Do;
          nbr_last   <= w_do_last;
          nbr_valid  <= 1'b1;
        end else if (w_acc) begin
          r_hold      <= RAM_NBR_Do;
          r_hold_last <= w_do_last;
          r_hold_v    <= 1'b1;
        end
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/nbr_list_reader.md
Name: nbr_list_reader

Overview:
- Read-side client of the neighbor RAM that the neighbor builder populates.
- On request, looks up one vertex's neighbor list and streams the neighbors out one per beat on a valid/ready interface.
- Ends each request with a done pulse carrying the list length and an error flag.
- Consumers are the downstream subdivision stages (edge-point and vertex-point computation), which need per-vertex adjacency.

Parameters:
- MAX_NEIGHBOR_COUNT, 10: words per vertex record. Word 0 holds the count in bits [3:0]; words 1..MAX_NEIGHBOR_COUNT-1 hold neighbor indices.
- VERTEX_MAX, 51: highest legal 1-based vertex index. (VERTEX_MAX*MAX_NEIGHBOR_COUNT-1) must be ≤ 511.

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_vertex  input  32  1-based vertex index to look up
- nbr_valid  output  1  nbr_vertex valid
- nbr_ready  input  1  consumer accepts beat
- nbr_vertex  output  32  neighbor index
- nbr_last  output  1  final beat of the current list
- done  output  1  one-cycle pulse at end of each request
- done_count  output  4  number of beats emitted for the request
- done_err  output  1  request error (range or count overflow); valid with done
- busy  output  1  request in progress
- RAM_NBR_EN  output  1  RAM enable
- RAM_NBR_A  output  9  RAM word address
- RAM_NBR_WE  output  4  byte write enables; tied to 0
- RAM_NBR_Di  output  32  write data; tied to 0
- RAM_NBR_Do  input  32  RAM read data

Behaviour:
- Reset (async, any time, including mid-request):
  - state IDLE; req_ready=1; nbr_valid=0; nbr_last=0; nbr_vertex=0.
  - done=0; done_count=0; done_err=0; busy=0.
  - RAM_NBR_EN=0; RAM_NBR_A=0; WE=0; Di=0.
  - Any in-flight request is discarded with no done.
- Outside reset: RAM_NBR_EN=1. WE and Di stay 0 at all times.
- RAM timing: RAM_NBR_Do in cycle N+1 holds the word addressed by RAM_NBR_A during cycle N (one-cycle read latency). All outputs are registered.
- Accept: req_valid && req_ready at a rising edge. req_ready=1 only in IDLE. busy=1 from the edge after accept until the edge after done.
- Address math: base = (req_vertex[8:0]-1)*MAX_NEIGHBOR_COUNT, truncated to 9 bits. Neighbor k (0-based) is at base+1+k.
- States:
  - IDLE: on accept with a legal vertex, drive A=base and go to CNT_WAIT. An illegal vertex (0 or >VERTEX_MAX) goes directly to DONE with err set; there is no RAM access.
  - CNT_WAIT: one cycle, then CNT_CAP.
  - CNT_CAP: latch cnt=Do[3:0].
    - If cnt > MAX_NEIGHBOR_COUNT-1, clamp cnt to MAX_NEIGHBOR_COUNT-1 and set err.
    - If cnt==0, go to DONE (no beats).
    - Otherwise drive A=base+1, k=0, go to NBR_WAIT.
  - NBR_WAIT: one cycle, then NBR_CAP.
  - NBR_CAP: load nbr_vertex=Do; nbr_last=(k==cnt-1); nbr_valid=1; go to EMIT.
  - EMIT: hold nbr_vertex, nbr_last and nbr_valid stable until nbr_ready.
    - On handshake with last set: go to DONE.
    - On handshake otherwise: k++, A=base+1+k, nbr_valid=0, go to NBR_WAIT.
  - DONE: done=1 for exactly one cycle, done_count=beats emitted, done_err=err. Return to IDLE.
- Latency (legal vertex, cnt≥1): first nbr_valid is asserted 4 cycles after the accept edge. Without prefetch, a new beat follows every 3 cycles. done asserts the cycle after the last handshake.
- done_count and done_err hold their values until the next done.
- nbr_ready asserted while nbr_valid=0 is ignored.
- req_valid asserted while busy is ignored and not queued.

Optional Feature:
- Macro: NBR_PREFETCH_EN.
- Defined:
  - A second 32-bit holding register is added.
  - While in EMIT, the address for beat k+1 is issued and its data captured into the holding register.
  - On handshake, the next beat is presented on the following cycle.
  - With nbr_ready held high, beats are back-to-back (1 per cycle) after the first.
  - First-beat latency is unchanged (4 cycles).
  - The address must never exceed base+cnt; no extra read past the list.
- Undefined: behaviour exactly as in Behaviour (3 cycles per beat).

Test Plan:
- Reset, then vertex 1 with RAM[0]=3, RAM[1..3]={2,5,7}, nbr_ready=1 → beats 2,5,7 with nbr_last on 7; first nbr_valid 4 cycles after accept; done_count=3, done_err=0.
- Vertex 4 with RAM[30]=0 → no nbr_valid; done 3 cycles after accept; done_count=0, done_err=0.
- Vertex 0, then vertex 52 → no RAM address change from 0; done 1 cycle after each accept; done_err=1, done_count=0.
- Vertex 2 with RAM[10]=15 → count clamped to 9; beats from RAM[11..19]; done_count=9, done_err=1.
- Vertex 1, 3 neighbors, with nbr_ready low for 5 cycles on beat 2 → nbr_vertex and nbr_last stable throughout the stall; order preserved. With NBR_PREFETCH_EN and nbr_ready=1, beats are on consecutive cycles.
- rst pulsed during EMIT of beat 2 → all outputs at reset values immediately; no done. The next request for vertex 1 returns the full list from beat 1.
